// File: rtl/stopwatch_ctrl_pkg.sv
// Shared mode encoding and select constants for the stopwatch mode controller.
// Encoding 2'd3 is unused; the controller treats it as RUN.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } mode_e;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    // Pause press while adjusting flips the mode we return to on exit.
    function automatic mode_e toggleMode(input mode_e m);
        return (m == ST_PAUSED) ? ST_RUN : ST_PAUSED;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_sw_debounce.sv
// Synchroniser plus counter debouncer for one bouncy board input.
// A change is accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   syncOut;

    assign syncOut = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (syncOut != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = syncOut;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounced buttons/switches drive the RUN/PAUSED/ADJUST machine,
// which gates the clk_div tick strobes into counter enables and drives the adjust blink.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_rst_raw,
    input  logic       btn_pause_raw,
    input  logic       sw_adjust_raw,
    input  logic       sw_select_raw,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    output logic       clear,
    output logic       count_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       blink_min,
    output logic       blink_sec,
    output logic [1:0] state
);

    logic  clrStable, pauseStable, adjStable, selStable;
    logic  clrPrev_q, pausePrev_q;
    logic  clearPress, pausePress;
    mode_e state_q, state_d, resume_q, resume_d;
    logic  clear_q, clear_d, countEn_q, countEn_d, adjEn_q, adjEn_d;
    logic  phase_q, phase_d;
    logic  inRun, inAdjust;

    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbRst (
        .clk(clk), .reset(reset), .raw(btn_rst_raw), .stable(clrStable));
    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbPause (
        .clk(clk), .reset(reset), .raw(btn_pause_raw), .stable(pauseStable));
    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbAdjust (
        .clk(clk), .reset(reset), .raw(sw_adjust_raw), .stable(adjStable));
    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbSelect (
        .clk(clk), .reset(reset), .raw(sw_select_raw), .stable(selStable));

    // Presses are rising edges of the debounced buttons; releases do nothing.
    assign clearPress = clrStable & ~clrPrev_q;
    assign pausePress = pauseStable & ~pausePrev_q;
    assign inAdjust   = (state_q == ST_ADJUST);
    assign inRun      = (state_q != ST_PAUSED) && (state_q != ST_ADJUST);

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        case (state_q)
            ST_ADJUST: begin
                if (clearPress) begin
                    resume_d = ST_RUN;
                end else if (pausePress) begin
                    resume_d = toggleMode(resume_q);
                end
                if (!adjStable) begin
                    state_d = resume_d;
                end
            end
            ST_PAUSED: begin
                if (adjStable) begin
                    state_d  = ST_ADJUST;
                    resume_d = clearPress ? ST_RUN : ST_PAUSED;
                end else if (clearPress || pausePress) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (adjStable) begin
                    state_d  = ST_ADJUST;
                    resume_d = ST_RUN;
                end else if (!clearPress && pausePress) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        clear_d   = clearPress;
        countEn_d = tick_1hz && inRun && !clearPress;
        adjEn_d   = tick_2hz && inAdjust && !clearPress;

        // Entering ADJUST always starts with digits visible.
        phase_d = phase_q;
        if ((state_d == ST_ADJUST) && !inAdjust) begin
            phase_d = 1'b0;
        end else if (inAdjust && tick_blink) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            clrPrev_q   <= 1'b0;
            pausePrev_q <= 1'b0;
            clear_q     <= 1'b0;
            countEn_q   <= 1'b0;
            adjEn_q     <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            clrPrev_q   <= clrStable;
            pausePrev_q <= pauseStable;
            clear_q     <= clear_d;
            countEn_q   <= countEn_d;
            adjEn_q     <= adjEn_d;
            phase_q     <= phase_d;
        end
    end

    assign clear     = clear_q;
    assign count_en  = countEn_q;
    assign adj_en    = adjEn_q;
    assign adj_sel   = selStable;
    assign blink_min = inAdjust && (selStable == SEL_MIN) && phase_q;
    assign blink_sec = inAdjust && (selStable == SEL_SEC) && phase_q;
    assign state     = state_q;

endmodule
